// File: rtl/amadeus_pkg.sv
// rtl/amadeus_pkg.sv - shared psum types, operating modes and lane-enable decode
package amadeus_pkg;

   localparam int PSUM_W = 16;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_K3   = 2'd1,
      MODE_K5   = 2'd2,
      MODE_K7   = 2'd3
   } OP_MODE;

   typedef struct packed {
      logic                     valid;
      logic signed [PSUM_W-1:0] data;
   } PSUM_PACKET;

   // Kernel size K uses the first K PE rows.
   function automatic logic [6:0] lane_mask(input OP_MODE mode);
      case (mode)
         MODE_K3: lane_mask = 7'h07;
         MODE_K5: lane_mask = 7'h1f;
         MODE_K7: lane_mask = 7'h7f;
         default: lane_mask = 7'h00;
      endcase
   endfunction

endpackage

// File: rtl/psum_fifo.sv
// rtl/psum_fifo.sv - single-lane synchronous FIFO with clear, registered head, no fall-through
module psum_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 rdata,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/psum_buffer.sv
// rtl/psum_buffer.sv - per-row psum staging FIFOs; PSUM_BUFFER_OCC_EN adds lane_occ/lane_ovf
import amadeus_pkg::*;

module psum_buffer #(
   parameter int DEPTH     = 16,
   parameter int NUM_LANES = 7
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start_conv,
   input  OP_MODE                                mode_in,
   input  PSUM_PACKET [6:0]                      psum_in,
   input  logic [6:0]                            pe_psum_ack,
   output logic [6:0]                            psum_buffer_ack,
   output PSUM_PACKET [6:0]                      psum_out
`ifdef PSUM_BUFFER_OCC_EN
   ,
   output logic [6:0][$clog2(DEPTH+1)-1:0]       lane_occ,
   output logic [6:0]                            lane_ovf
`endif
);
   localparam int CW = $clog2(DEPTH+1);

   OP_MODE                   mode_q;
   logic [6:0]               lane_en;
   logic [6:0]               empty;
   logic [6:0]               full;
   logic [6:0]               pop;
   logic [6:0][PSUM_W-1:0]   head;
   logic [6:0][CW-1:0]       occ;

   always_ff @(posedge clk) begin
      if (rst_n)
         mode_q <= MODE_IDLE;
      else if (start_conv)
         mode_q <= mode_in;
   end

   assign lane_en = lane_mask(mode_q);

   // start_conv clears every lane, so neither side may move that cycle.
   always_comb begin
      psum_buffer_ack = '0;
      psum_out        = '0;
      pop             = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         psum_buffer_ack[i] = psum_in[i].valid & lane_en[i] & ~full[i] & ~start_conv & ~rst_n;
         psum_out[i].valid  = lane_en[i] & ~empty[i];
         psum_out[i].data   = psum_out[i].valid ? head[i] : '0;
         pop[i]             = pe_psum_ack[i] & psum_out[i].valid & ~start_conv & ~rst_n;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      psum_fifo #(
         .W     (PSUM_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst_n),
         .clr   (start_conv),
         .push  (psum_buffer_ack[g]),
         .pop   (pop[g]),
         .wdata (psum_in[g].data),
         .rdata (head[g]),
         .empty (empty[g]),
         .full  (full[g]),
         .count (occ[g])
      );
   end

`ifdef PSUM_BUFFER_OCC_EN
   assign lane_occ = occ;

   always_ff @(posedge clk) begin
      if (rst_n || start_conv) begin
         lane_ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++)
            if (psum_in[i].valid && lane_en[i] && full[i])
               lane_ovf[i] <= 1'b1;
      end
   end
`else
   logic unused_occ;
   assign unused_occ = ^occ;
`endif

endmodule

// File: tb/tb_psum_buffer.sv
// tb/tb_psum_buffer.sv - directed self-checking bench for psum_buffer
import amadeus_pkg::*;

module tb_psum_buffer;
   localparam int DEPTH = 16;

   logic             clk;
   logic             rst_n;
   logic             start_conv;
   OP_MODE           mode_in;
   PSUM_PACKET [6:0] psum_in;
   logic [6:0]       pe_psum_ack;
   logic [6:0]       psum_buffer_ack;
   PSUM_PACKET [6:0] psum_out;
`ifdef PSUM_BUFFER_OCC_EN
   logic [6:0][$clog2(DEPTH+1)-1:0] lane_occ;
   logic [6:0]                      lane_ovf;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   psum_buffer #(.DEPTH(DEPTH), .NUM_LANES(7)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_conv      (start_conv),
      .mode_in         (mode_in),
      .psum_in         (psum_in),
      .pe_psum_ack     (pe_psum_ack),
      .psum_buffer_ack (psum_buffer_ack),
      .psum_out        (psum_out)
`ifdef PSUM_BUFFER_OCC_EN
      ,
      .lane_occ        (lane_occ),
      .lane_ovf        (lane_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic PSUM_PACKET pk(input int v);
      PSUM_PACKET p;
      p.valid = 1'b1;
      p.data  = v[15:0];
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input OP_MODE m);
      mode_in    = m;
      start_conv = 1'b1;
      tick();
      start_conv = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b1;
      start_conv  = 1'b0;
      mode_in     = MODE_IDLE;
      psum_in     = '0;
      pe_psum_ack = '0;
      tick();
      tick();
      check("reset_ack", psum_buffer_ack, 7'h00);
      check("reset_out", psum_out, '0);
      rst_n = 1'b0;

      // Idle mode: nothing accepted
      start(MODE_IDLE);
      for (int i = 0; i < 7; i++) psum_in[i] = pk(1);
      #1 check("idle_ack", psum_buffer_ack, 7'h00);
      tick();
      check("idle_out", psum_out, '0);
      psum_in = '0;

      // K3: lane 1 push 5, -3, 7 then pop
      mode_in = MODE_K3;
      start_conv = 1'b1;
      psum_in[1] = pk(5);
      #1 check("start_forces_ack0", psum_buffer_ack, 7'h00);
      tick();
      start_conv = 1'b0;
      #1 check("k3_push5_ack", psum_buffer_ack, 7'h02);
      check("k3_no_fallthrough", psum_out[1], '0);
      tick();
      psum_in[1] = pk(-3);
      #1 check("k3_push_m3_ack", psum_buffer_ack, 7'h02);
      check("k3_head5_visible", psum_out[1], pk(5));
      tick();
      psum_in[1] = pk(7);
      #1 check("k3_push7_ack", psum_buffer_ack, 7'h02);
      tick();
      psum_in = '0;
      pe_psum_ack[1] = 1'b1;
      #1 check("k3_pop5", psum_out[1], pk(5));
      tick();
      check("k3_pop_m3", psum_out[1], pk(-3));
      tick();
      check("k3_pop7", psum_out[1], pk(7));
      tick();
      check("k3_empty", psum_out[1], '0);
      pe_psum_ack = '0;

      // Lane 5 disabled in K3, enabled in K7
      psum_in[5] = pk(9);
      #1 check("k3_lane5_ack", psum_buffer_ack, 7'h00);
      tick();
      check("k3_lane5_out", psum_out[5], '0);
      mode_in = MODE_K7;
      start_conv = 1'b1;
      #1 check("k7_start_ack0", psum_buffer_ack, 7'h00);
      tick();
      start_conv = 1'b0;
      #1 check("k7_lane5_ack", psum_buffer_ack, 7'h20);
      tick();
      psum_in = '0;
      #1 check("k7_lane5_out", psum_out[5], pk(9));

      // Fill lane 0, full behaviour, drain with wrap
      start(MODE_K3);
      for (int i = 0; i < DEPTH; i++) begin
         psum_in[0] = pk(i);
         #1 check($sformatf("fill_ack_%0d", i), psum_buffer_ack[0], 1'b1);
         tick();
      end
      psum_in[0] = pk(99);
      #1 check("full_ack0", psum_buffer_ack[0], 1'b0);
      check("full_head0", psum_out[0], pk(0));
      pe_psum_ack[0] = 1'b1;
      #1 check("full_pushpop_ack0", psum_buffer_ack[0], 1'b0);
      tick();
      psum_in = '0;
      for (int i = 1; i < DEPTH; i++) begin
         #1 check($sformatf("drain_%0d", i), psum_out[0], pk(i));
         tick();
      end
      check("drain_empty", psum_out[0], '0);
      pe_psum_ack = '0;

      // Lane 2: 4 entries, 10 cycles simultaneous push/pop
      start(MODE_K3);
      for (int i = 0; i < 4; i++) begin
         psum_in[2] = pk(10 + i);
         tick();
      end
      pe_psum_ack[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         psum_in[2] = pk(14 + k);
         #1 check($sformatf("pp_head_%0d", k), psum_out[2], pk(10 + k));
         check($sformatf("pp_ack_%0d", k), psum_buffer_ack[2], 1'b1);
         tick();
      end
      psum_in = '0;
      for (int k = 0; k < 4; k++) begin
         #1 check($sformatf("pp_drain_%0d", k), psum_out[2], pk(20 + k));
         tick();
      end
      check("pp_empty", psum_out[2], '0);
      pe_psum_ack = '0;
      psum_in[2] = pk(1);
      tick();
      psum_in[2] = pk(2);
      tick();
      psum_in = '0;
      check("mid_head", psum_out[2], pk(1));
      pe_psum_ack[2] = 1'b1;
      start(MODE_K3);
      pe_psum_ack = '0;
      check("mid_start_clears", psum_out, '0);

`ifdef PSUM_BUFFER_OCC_EN
      for (int i = 0; i < 3; i++) begin
         psum_in[0] = pk(i);
         tick();
      end
      check("occ_3", lane_occ[0], 5'd3);
      check("ovf_clear", lane_ovf, 7'h00);
      for (int i = 3; i < DEPTH; i++) begin
         psum_in[0] = pk(i);
         tick();
      end
      check("occ_full", lane_occ[0], 5'd16);
      tick();
      psum_in = '0;
      check("ovf_set", lane_ovf, 7'h01);
      tick();
      check("ovf_sticky", lane_ovf, 7'h01);
      start(MODE_K3);
      check("ovf_cleared", lane_ovf, 7'h00);
      check("occ_cleared", lane_occ[0], 5'd0);
`endif

      // Reset mid-operation discards data and returns to idle
      psum_in[0] = pk(5);
      tick();
      psum_in = '0;
      check("pre_reset_head", psum_out[0], pk(5));
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      check("rst_mid_out", psum_out, '0);
      psum_in[0] = pk(6);
      #1 check("rst_mid_idle_ack", psum_buffer_ack, 7'h00);
      psum_in = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
